// File: rtl/eq_gain_ctrl_if.sv
// Beat-level handshake between the gain controller and the coefficient loader.
// The controller drives band/gain beats; the loader answers with cfg_ready.
interface eq_gain_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_band;
  logic [4:0] cfg_gain;
  logic       cfg_last;

  modport master (
    output cfg_valid,
    output cfg_band,
    output cfg_gain,
    output cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_band,
    input  cfg_gain,
    input  cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/eq_gain_ctrl.sv
// Equalizer gain controller: decodes touch commands into per-band gains and
// streams all band gains to the coefficient loader on commit.
module eq_gain_ctrl #(
  parameter int NUM_BANDS = 10,
  parameter int GAIN_MAX  = 12
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic [11:0]         button_ord,
  eq_gain_ctrl_if.master      cfg,
  output logic [3:0]          sel_band,
  output logic signed [4:0]   sel_gain,
  output logic                busy,
  output logic                done,
  output logic                mute
);

  localparam logic [3:0]        LAST_BAND = 4'(NUM_BANDS - 1);
  localparam logic signed [4:0] GAIN_HI   = 5'(GAIN_MAX);
  localparam logic signed [4:0] GAIN_LO   = -5'(GAIN_MAX);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            state;
  logic signed [4:0] gain [NUM_BANDS];
  logic [3:0]        beat_idx;
  logic              commit_pending;

  logic       cmd_hit;
  logic [3:0] cmd_idx;
  logic       load_cmd;
  logic       commit_cmd;
  logic [1:0] preset_sel;

  function automatic logic signed [4:0] preset_gain(input logic [1:0] p, input int b);
    logic signed [4:0] g;
    g = '0;
    case (p)
      2'd1: if (b <= 2)           g = 5'sd6;
      2'd2: if (b >= 7 && b <= 9) g = 5'sd6;
      2'd3: if (b == 4 || b == 5) g = 5'sd4;
      default: g = '0;
    endcase
    return g;
  endfunction

  // Lowest set bit among 0..10 wins; scanning downward leaves the lowest one.
  always_comb begin
    cmd_hit = 1'b0;
    cmd_idx = '0;
    for (int i = 10; i >= 0; i--) begin
      if (button_ord[i]) begin
        cmd_hit = 1'b1;
        cmd_idx = 4'(i);
      end
    end
    load_cmd   = cmd_hit && (cmd_idx >= 4'd5) && (cmd_idx <= 4'd9);
    commit_cmd = cmd_hit && (cmd_idx == 4'd10);
    preset_sel = (cmd_idx == 4'd5) ? 2'd0 : 2'(cmd_idx - 4'd6);
  end

  assign sel_gain     = gain[sel_band];
  assign cfg.cfg_gain = cfg.cfg_valid ? gain[beat_idx] : 5'd0;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      beat_idx       <= '0;
      commit_pending <= 1'b0;
      sel_band       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mute           <= 1'b0;
      cfg.cfg_valid  <= 1'b0;
      cfg.cfg_band   <= '0;
      cfg.cfg_last   <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) gain[b] <= '0;
    end else begin
      done <= 1'b0;
      if (button_ord[11]) mute <= ~mute;

      case (state)
        IDLE: begin
          if (cmd_hit) begin
            case (cmd_idx)
              4'd0: sel_band <= (sel_band == 4'd0) ? LAST_BAND : sel_band - 4'd1;
              4'd1: sel_band <= (sel_band == LAST_BAND) ? 4'd0 : sel_band + 4'd1;
              4'd2: if (gain[sel_band] < GAIN_HI) gain[sel_band] <= gain[sel_band] + 5'sd1;
              4'd3: if (gain[sel_band] > GAIN_LO) gain[sel_band] <= gain[sel_band] - 5'sd1;
              4'd4: gain[sel_band] <= '0;
              default: begin
                if (load_cmd) begin
                  for (int b = 0; b < NUM_BANDS; b++) gain[b] <= preset_gain(preset_sel, b);
                end
              end
            endcase
          end
          // A load arms a commit for the following cycle so the new gains are settled.
          commit_pending <= load_cmd && !commit_pending;
          if (commit_pending || commit_cmd) begin
            state         <= SEND;
            beat_idx      <= '0;
            busy          <= 1'b1;
            cfg.cfg_valid <= 1'b1;
            cfg.cfg_band  <= '0;
            cfg.cfg_last  <= (LAST_BAND == 4'd0);
          end
        end

        SEND: begin
          commit_pending <= 1'b0;
          if (cfg.cfg_ready) begin
            if (beat_idx == LAST_BAND) begin
              state         <= DONE;
              done          <= 1'b1;
              cfg.cfg_valid <= 1'b0;
              cfg.cfg_band  <= '0;
              cfg.cfg_last  <= 1'b0;
            end else begin
              beat_idx     <= beat_idx + 4'd1;
              cfg.cfg_band <= beat_idx + 4'd1;
              cfg.cfg_last <= ((beat_idx + 4'd1) == LAST_BAND);
            end
          end
        end

        DONE: begin
          commit_pending <= 1'b0;
          state          <= IDLE;
          busy           <= 1'b0;
        end

        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          commit_pending <= 1'b0;
          cfg.cfg_valid  <= 1'b0;
          cfg.cfg_band   <= '0;
          cfg.cfg_last   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// Directed bench for eq_gain_ctrl: navigation, gain saturation, presets,
// commit handshake with back-pressure, command priority and reset abort.
module tb_eq_gain_ctrl;

  logic        pclk;
  logic        rst_n;
  logic [11:0] button_ord;
  logic [3:0]  sel_band;
  logic [4:0]  sel_gain;
  logic        busy;
  logic        done;
  logic        mute;

  eq_gain_ctrl_if cfg_bus();

  eq_gain_ctrl #(.NUM_BANDS(10), .GAIN_MAX(12)) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .button_ord (button_ord),
    .cfg        (cfg_bus),
    .sel_band   (sel_band),
    .sel_gain   (sel_gain),
    .busy       (busy),
    .done       (done),
    .mute       (mute)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge, after the command took effect.
  task automatic pulse(input logic [11:0] b);
    button_ord = b;
    @(negedge pclk);
    button_ord = '0;
  endtask

  int          eg [10];
  int          e;
  logic [4:0]  e5;
  int          busy_cnt;
  int          done_cnt;
  int          idx;
  bit          sending;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    button_ord = '0;
    cfg_bus.cfg_ready = 1'b0;
    repeat (3) @(negedge pclk);

    chk("rst_sel_band", {28'd0, sel_band}, 32'd0);
    chk("rst_sel_gain", {27'd0, sel_gain}, 32'd0);
    chk("rst_cfg_valid", {31'd0, cfg_bus.cfg_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mute", {31'd0, mute}, 32'd0);
    rst_n = 1'b1;

    // Band navigation with wrap in both directions
    for (int i = 0; i < 11; i++) begin
      pulse(12'h002);
      chk("next_band", {28'd0, sel_band}, 32'((i + 1) % 10));
    end
    pulse(12'h001);
    chk("prev_band_a", {28'd0, sel_band}, 32'd0);
    pulse(12'h001);
    chk("prev_band_wrap", {28'd0, sel_band}, 32'd9);

    repeat (4) pulse(12'h002);
    chk("band3", {28'd0, sel_band}, 32'd3);

    // Gain saturation
    for (int i = 0; i < 15; i++) begin
      pulse(12'h004);
      e = (i + 1 > 12) ? 12 : i + 1;
      e5 = e[4:0];
      chk("gain_up", {27'd0, sel_gain}, {27'd0, e5});
    end
    for (int i = 0; i < 30; i++) begin
      pulse(12'h008);
      e = (12 - (i + 1) < -12) ? -12 : 12 - (i + 1);
      e5 = e[4:0];
      chk("gain_down", {27'd0, sel_gain}, {27'd0, e5});
    end
    chk("gain_min_raw", {27'd0, sel_gain}, 32'h14);

    // Preset 1 with auto-commit, loader always ready
    for (int b = 0; b < 10; b++) eg[b] = (b <= 2) ? 6 : 0;
    cfg_bus.cfg_ready = 1'b1;
    pulse(12'h080);
    chk("preset_pend_valid", {31'd0, cfg_bus.cfg_valid}, 32'd0);
    chk("preset_pend_busy", {31'd0, busy}, 32'd0);
    chk("preset_sel_gain", {27'd0, sel_gain}, 32'd0);
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 13; k++) begin
      @(negedge pclk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (k < 10) begin
        e5 = eg[k][4:0];
        chk("p1_valid", {31'd0, cfg_bus.cfg_valid}, 32'd1);
        chk("p1_band", {28'd0, cfg_bus.cfg_band}, 32'(k));
        chk("p1_gain", {27'd0, cfg_bus.cfg_gain}, {27'd0, e5});
        chk("p1_last", {31'd0, cfg_bus.cfg_last}, (k == 9) ? 32'd1 : 32'd0);
      end else if (k == 10) begin
        chk("p1_done", {31'd0, done}, 32'd1);
        chk("p1_done_valid", {31'd0, cfg_bus.cfg_valid}, 32'd0);
        chk("p1_done_band", {28'd0, cfg_bus.cfg_band}, 32'd0);
      end
    end
    chk("p1_busy_cycles", 32'(busy_cnt), 32'd11);
    chk("p1_done_count", 32'(done_cnt), 32'd1);

    // Commit with back-pressure and commands injected mid-sequence
    pulse(12'h004);
    pulse(12'h004);
    chk("band3_gain2", {27'd0, sel_gain}, 32'd2);
    eg[3] = 2;
    cfg_bus.cfg_ready = 1'b0;
    pulse(12'h400);
    chk("commit_busy", {31'd0, busy}, 32'd1);
    idx = 0;
    sending = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (sending) begin
        e5 = eg[idx][4:0];
        chk("bp_valid", {31'd0, cfg_bus.cfg_valid}, 32'd1);
        chk("bp_band", {28'd0, cfg_bus.cfg_band}, 32'(idx));
        chk("bp_gain", {27'd0, cfg_bus.cfg_gain}, {27'd0, e5});
        chk("bp_last", {31'd0, cfg_bus.cfg_last}, (idx == 9) ? 32'd1 : 32'd0);
      end else begin
        chk("bp_done", {31'd0, done}, 32'd1);
        chk("bp_done_valid", {31'd0, cfg_bus.cfg_valid}, 32'd0);
        done_cnt++;
        break;
      end
      cfg_bus.cfg_ready = (c % 2) == 1;
      button_ord = (c == 3) ? 12'h004 : (c == 5) ? 12'h020 : (c == 7) ? 12'h800 : 12'h000;
      @(negedge pclk);
      if (cfg_bus.cfg_ready) begin
        if (idx == 9) sending = 1'b0;
        else idx++;
      end
    end
    button_ord = '0;
    cfg_bus.cfg_ready = 1'b1;
    chk("bp_completed", 32'(done_cnt), 32'd1);
    @(negedge pclk);
    chk("bp_after_done", {31'd0, done}, 32'd0);
    chk("bp_after_busy", {31'd0, busy}, 32'd0);
    chk("bp_mute", {31'd0, mute}, 32'd1);
    chk("bp_gain_kept", {27'd0, sel_gain}, 32'd2);

    // Same-cycle priority: next band wins, no gain change, no commit
    pulse(12'h406);
    chk("prio_band", {28'd0, sel_band}, 32'd4);
    chk("prio_gain", {27'd0, sel_gain}, 32'd0);
    chk("prio_busy", {31'd0, busy}, 32'd0);
    chk("prio_valid", {31'd0, cfg_bus.cfg_valid}, 32'd0);
    @(negedge pclk);
    chk("prio_no_commit", {31'd0, busy}, 32'd0);

    // Reset during the 4th beat aborts the commit
    pulse(12'h400);
    repeat (3) @(negedge pclk);
    chk("abort_band", {28'd0, cfg_bus.cfg_band}, 32'd3);
    chk("abort_valid_pre", {31'd0, cfg_bus.cfg_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, cfg_bus.cfg_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge pclk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (12) begin
      @(negedge pclk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_mute", {31'd0, mute}, 32'd0);
    chk("abort_sel_band", {28'd0, sel_band}, 32'd0);
    for (int b = 0; b < 10; b++) begin
      chk("abort_gain_zero", {27'd0, sel_gain}, 32'd0);
      pulse(12'h002);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eq_gain_ctrl.md
EQ_GAIN_CTRL -- requirements
Module: eq_gain_ctrl

Interface
REQ-001 Parameter NUM_BANDS, default 10: number of equalizer bands; band index width is 4 bits.
REQ-002 Parameter GAIN_MAX, default 12: gain limit in dB; gains are signed 5-bit values in the range -GAIN_MAX..+GAIN_MAX.
REQ-003 pclk  in  1  single system clock; all logic is rising-edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 button_ord  in  12  one-cycle command pulses from the touch front end.
REQ-006 cfg_ready  in  1  coefficient loader accepts the current beat.
REQ-007 cfg_valid  out  1  beat valid toward the coefficient loader.
REQ-008 cfg_band  out  4  band index of the current beat.
REQ-009 cfg_gain  out  5  signed gain of the current beat.
REQ-010 cfg_last  out  1  marks the beat for band NUM_BANDS-1.
REQ-011 sel_band  out  4  currently selected band, for display.
REQ-012 sel_gain  out  5  gain of the selected band, for display.
REQ-013 busy  out  1  high while a commit sequence is in progress.
REQ-014 done  out  1  one-cycle pulse when a commit completes.
REQ-015 mute  out  1  output mute flag.

Function
REQ-016 Command map (button_ord bit = command):
- 0 = previous band
- 1 = next band
- 2 = gain +1
- 3 = gain -1
- 4 = selected band to 0
- 5 = all bands to 0
- 6..9 = load preset 0..3
- 10 = commit
- 11 = mute toggle
REQ-017 Bits 0-10: if several are high in the same cycle, only the lowest-index bit is executed; the others are dropped.
REQ-018 Bit 11 is evaluated independently of bits 0-10 and in every state, including while busy.
REQ-019 A command pulse at cycle n SHALL be reflected in the registers and outputs at cycle n+1.
REQ-020 Band select wraps around: "next" from NUM_BANDS-1 goes to 0; "previous" from 0 goes to NUM_BANDS-1.
REQ-021 Gain +1/-1 saturates at +GAIN_MAX and -GAIN_MAX; there is no wrap.
REQ-022 Preset contents (all bands not listed are 0):
- Preset 0: all bands 0.
- Preset 1: bands 0-2 = +6.
- Preset 2: bands 7-9 = +6.
- Preset 3: bands 4-5 = +4.
REQ-023 Preset load and all-zero load (bit 5) write every band in one cycle and automatically start a commit on the next cycle; sel_band is unchanged.
REQ-024 State machine states are IDLE, SEND and DONE.
REQ-025 IDLE -> SEND on commit or auto-commit; the cfg beat index is set to 0.
REQ-026 In SEND, cfg_valid=1, cfg_band=index, cfg_gain=gain[index], and cfg_last=(index==NUM_BANDS-1).
REQ-027 A beat transfers on a cycle where cfg_valid and cfg_ready are both high; the index advances on the next cycle.
REQ-028 While cfg_ready=0, cfg_band, cfg_gain and cfg_last SHALL hold stable.
REQ-029 The transfer of the last beat -> DONE: done=1 and cfg_valid=0 for exactly one cycle, then IDLE.
REQ-030 busy=1 in SEND and DONE; button bits 0-10 received while busy are dropped (not queued).
REQ-031 Outside SEND, cfg_valid=0 and cfg_band/cfg_gain/cfg_last=0.
REQ-032 A commit with cfg_ready held high takes NUM_BANDS cycles in SEND plus 1 cycle in DONE.

Reset
REQ-033 When rst_n is low, asynchronously: state=IDLE, all gains=0, sel_band=0, beat index=0, and all outputs=0 (mute=0, cfg_valid=0).
REQ-034 Assertion of reset during SEND aborts the sequence immediately; no done pulse is generated.
REQ-035 After rst_n deasserts, the block accepts a command on the first rising edge.

Verification
REQ-036 Reset, then pulse bit 1 eleven times -> sel_band shows 1,2,...,9,0,1; then pulse bit 0 twice -> sel_band=9.
REQ-037 Pulse bit 2 fifteen times on band 3 -> sel_gain=12; then pulse bit 3 thirty times -> sel_gain=-12 (0x14).
REQ-038 Pulse bit 7 (preset 1) with cfg_ready=1 -> SEND starts 2 cycles after the pulse; beats are band0..9 with gains 6,6,6,0,...,0; cfg_last is high on band 9; done pulses once; busy is high for 11 cycles.
REQ-039 Pulse commit with cfg_ready toggling 1/0 -> each beat holds until accepted; bits 2 and 5 pulsed mid-sequence have no effect on any gain; a bit 11 pulse mid-sequence toggles mute to 1.
REQ-040 Drive bits 1, 2 and 10 high in the same cycle -> only "next band" executes; no commit starts.
REQ-041 Assert rst_n=0 on the 4th beat of a commit -> cfg_valid=0 immediately; after release, all gains read 0 and there is no done pulse.
